uart_tx_mmio: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_mmio_sync_fifo.sv | 46 ++++
 rtl/uart_tx_mmio.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int TXDATA_OFS = 0;
  localparam int STATUS_OFS = 1;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_PARITY  = 8;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is visible on dout without a pop.
// A pop on a full FIFO frees the slot for a push on the same edge; no empty bypass.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q, wp_d, rp_q, rp_d;
  logic             do_push, do_pop;

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  assign count   = wp_q - rp_q;
  assign dout    = mem_q[rp_q[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wp_d    = do_push ? wp_q + 1'b1 : wp_q;
  assign rp_d    = do_pop ? rp_q + 1'b1 : rp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: TXDATA store pushes a byte, STATUS load is combinational, 8N1 serial out.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wmem,
  input  logic        rmem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        irq
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t      state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           irq_q, ovf_q, ovf_d;
  logic           fifo_full, fifo_empty, pop, bit_end;
  logic [CW-1:0]  fifo_count;
  logic [7:0]     fifo_dout;
  logic           tx_hit, st_hit, wr_tx, rd_st;
  logic [31:0]    status;
  logic           unused_wdata;

  assign tx_hit       = (addr == BASE_ADDR + 32'(TXDATA_OFS));
  assign st_hit       = (addr == BASE_ADDR + 32'(STATUS_OFS));
  assign hit          = tx_hit || st_hit;
  assign wr_tx        = wmem && tx_hit;
  assign rd_st        = rmem && st_hit;
  assign unused_wdata = ^wdata[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .pop   (pop),
    .din   (wdata[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .dout  (fifo_dout)
  );

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  assign par_d = pop ? ^fifo_dout : par_q;
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));
    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        shift_d = fifo_dout;
        state_d = START;
        baud_d  = '0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
      PARITY: if (bit_end) state_d = STOP;
      // Chain straight into the next START so back-to-back frames have no idle gap.
      STOP: if (bit_end) begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (rd_st) ovf_d = 1'b0;
    if (wr_tx && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= fifo_empty && (state_q == IDLE);
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    status                   = '0;
    status[ST_FULL]          = fifo_full;
    status[ST_EMPTY]         = fifo_empty;
    status[ST_BUSY]          = (state_q != IDLE);
    status[ST_OVF]           = ovf_q;
    status[ST_CNT_LSB +: 4]  = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
`ifdef UART_TX_PARITY_EN
    status[ST_PARITY]        = 1'b1;
`endif
  end

  assign rdata = rd_st ? status : 32'h0;
  assign tx    = tx_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at CLKS_PER_BIT=4, FIFO_DEPTH=8 (default 8N1 build).
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam logic [31:0] STAT = 32'h0000_0401;

  logic        clk = 1'b0;
  logic        rst, wmem, rmem;
  logic [31:0] addr, wdata, rdata;
  logic        hit, tx, irq;
  int          n_chk = 0;
  int          n_fail = 0;

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wmem(wmem), .rmem(rmem), .addr(addr),
    .wdata(wdata), .rdata(rdata), .hit(hit), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    wmem = 1'b1; addr = a; wdata = {24'hABCDEF, d};
    step(1);
    wmem = 1'b0; addr = 32'h0;
  endtask

  task automatic rd_status(input string tag, input logic [31:0] exp);
    rmem = 1'b1; addr = STAT;
    #1;
    chk(tag, rdata, exp);
    step(1);
    rmem = 1'b0; addr = 32'h0;
  endtask

  logic [9:0] a5_bits;
  logic       fell;

  initial begin
    rst = 1'b1; wmem = 1'b0; rmem = 1'b0; addr = 32'h0; wdata = 32'h0;
    step(3);
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd1);
    rd_status("rst_status", 32'h0000_0002);

    addr = BASE;          #1; chk("hit_txdata", 32'(hit), 32'd1);
    addr = STAT;          #1; chk("hit_status", 32'(hit), 32'd1);
    addr = 32'h0000_0402; #1; chk("hit_above", 32'(hit), 32'd0);
    addr = 32'h0000_03FF; #1; chk("hit_below", 32'(hit), 32'd0);
    rmem = 1'b1; addr = BASE; #1; chk("rd_txdata_zero", rdata, 32'h0);
    addr = 32'h0000_0500;     #1; chk("rd_outside_zero", rdata, 32'h0);
    rmem = 1'b0;

    // Stores to STATUS or outside the window must not enqueue anything.
    wr(STAT, 8'h5A);
    wr(32'h0000_0500, 8'h5A);
    step(2);
    chk("ign_tx", 32'(tx), 32'd1);
    chk("ign_irq", 32'(irq), 32'd1);
    rd_status("ign_status", 32'h0000_0002);

    // Single byte A5: start, LSB-first data, stop.
    a5_bits = 10'b1_10100101_0;
    wr(BASE, 8'hA5);
    step(1);
    chk("a5_start_edge", 32'(tx), 32'd0);
    chk("a5_irq_low", 32'(irq), 32'd0);
    step(2);
    chk("a5_bit0", 32'(tx), 32'(a5_bits[0]));
    for (int k = 1; k < 10; k++) begin
      step(4);
      chk($sformatf("a5_bit%0d", k), 32'(tx), 32'(a5_bits[k]));
    end
    step(1);
    chk("a5_irq_stop_end", 32'(irq), 32'd0);
    step(1);
    chk("a5_irq_idle_entry", 32'(irq), 32'd0);
    chk("a5_tx_idle", 32'(tx), 32'd1);
    step(1);
    chk("a5_irq_rise", 32'(irq), 32'd1);

    // Back-to-back 00 then FF: second START exactly 40 cycles after the first.
    wr(BASE, 8'h00);
    wr(BASE, 8'hFF);
    rd_status("b2b_status_start", 32'h0000_0014);
    step(38);
    chk("b2b_stop1", 32'(tx), 32'd1);
    rd_status("b2b_status_stop1", 32'h0000_0014);
    chk("b2b_start2", 32'(tx), 32'd0);
    rd_status("b2b_status_frame2", 32'h0000_0006);
    step(1);
    chk("b2b_start2_mid", 32'(tx), 32'd0);
    step(4);
    chk("b2b_ff_bit0", 32'(tx), 32'd1);
    step(35);
    chk("b2b_irq_done", 32'(irq), 32'd1);
    rd_status("b2b_status_done", 32'h0000_0002);

    // Overflow: one byte in the shifter, then nine stores into an 8-entry FIFO.
    wr(BASE, 8'hC3);
    step(2);
    for (int i = 0; i < 9; i++) wr(BASE, 8'h10 + 8'(i));
    rd_status("ovf_status", 32'h0000_008D);
    rd_status("ovf_cleared", 32'h0000_0085);

    // Full FIFO written on the edge the shifter pops: accepted, no overflow.
    step(27);
    wr(BASE, 8'h55);
    chk("fullpop_start", 32'(tx), 32'd0);
    rd_status("fullpop_status", 32'h0000_0085);

    // Reset in the middle of data bit 3 of byte 0x10.
    step(16);
    chk("mid_bit3", 32'(tx), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_irq", 32'(irq), 32'd1);
    rd_status("mid_rst_status", 32'h0000_0002);
    fell = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (tx !== 1'b1) fell = 1'b1;
    end
    chk("mid_rst_no_resume", 32'(fell), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
